alu_arbiter: RTL and testbench

Shares one combinational 32-bit ALU between two requesters, such as the integer pipe and an address/debug engine. Each requester issues an operation over a valid/ready handshake. A round-robin arbiter grants one request at a time, and a 3-state FSM sequences the operation: capture operands, execute through the registered ALU, then hold the result until the requester accepts it. Result and error are returned on a per-requester valid/ready response channel.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: widths, function codes, FSM encoding
// and the function-code legality check.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int FUNC_W = 3;

   localparam logic [FUNC_W-1:0] ALU_ADD = 3'b001;
   localparam logic [FUNC_W-1:0] ALU_SUB = 3'b010;
   localparam logic [FUNC_W-1:0] ALU_AND = 3'b011;
   localparam logic [FUNC_W-1:0] ALU_OR  = 3'b100;
   localparam logic [FUNC_W-1:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic is_legal_func(input logic [FUNC_W-1:0] f);
      logic legal;
      case (f)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU; illegal function codes produce zero.
import alu_pkg::*;

module alu (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [FUNC_W-1:0] alu_func,
   output logic [DATA_W-1:0] data_out
);

   logic signed [DATA_W-1:0] w_a_s;
   logic signed [DATA_W-1:0] w_b_s;

   assign w_a_s = a;
   assign w_b_s = b;

   always_comb begin
      data_out = '0;
      case (alu_func)
         ALU_ADD: data_out = a + b;
         ALU_SUB: data_out = a - b;
         ALU_AND: data_out = a & b;
         ALU_OR:  data_out = a | b;
         ALU_SLT: data_out = {{(DATA_W-1){1'b0}}, (w_a_s < w_b_s)};
         default: data_out = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters: IDLE grants and captures,
// EXEC registers the ALU result, RESP holds it until the owning requester takes it.
import alu_pkg::*;

module alu_arbiter (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [FUNC_W-1:0] req0_func,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [FUNC_W-1:0] req1_func,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   logic [1:0]        r_state;
   logic              r_last_grant;
   logic              r_id;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [FUNC_W-1:0] r_func;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic              r_rsp0_valid;
   logic              r_rsp1_valid;

   logic              w_grant;
   logic              w_idle;
   logic              w_accept;
   logic              w_rsp_take;
   logic [DATA_W-1:0] w_alu_out;

   // Contention alternates against the previous winner; a lone requester always wins.
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end
   end

   assign w_idle     = (r_state == ST_IDLE);
   assign req0_ready = w_idle & req0_valid & ~w_grant;
   assign req1_ready = w_idle & req1_valid &  w_grant;
   assign w_accept   = req0_ready | req1_ready;
   assign w_rsp_take = r_id ? rsp1_ready : rsp0_ready;

   alu u_alu (
      .a        (r_a),
      .b        (r_b),
      .alu_func (r_func),
      .data_out (w_alu_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_func       <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a          <= w_grant ? req1_a    : req0_a;
                  r_b          <= w_grant ? req1_b    : req0_b;
                  r_func       <= w_grant ? req1_func : req0_func;
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  r_state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rsp_data <= w_alu_out;
               r_rsp_err  <= ~is_legal_func(r_func);
               if (r_id) begin
                  r_rsp1_valid <= 1'b1;
               end else begin
                  r_rsp0_valid <= 1'b1;
               end
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               // Only the owning channel's ready can retire the result.
               if (w_rsp_take) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed results, latency, fairness, hold and reset abort.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_func, req1_func;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   int n_vec;
   int n_err;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_func  (req0_func),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_func  (req1_func),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " req0_ready"}, {31'd0, req0_ready}, 32'd0);
      chk({tag, " req1_ready"}, {31'd0, req1_ready}, 32'd0);
      chk({tag, " rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
      chk({tag, " rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
      chk({tag, " rsp_data"},   rsp_data,             32'd0);
      chk({tag, " rsp_err"},    {31'd0, rsp_err},     32'd0);
   endtask

   task automatic apply_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk_all_zero("reset");
      tick();
      rst = 1'b0;
      #1;
   endtask

   // Single uncontended operation: accept, EXEC, RESP with ready already high.
   task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] exp_d, input logic exp_e);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      if (r == 0) begin
         req0_a = a; req0_b = b; req0_func = f; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_func = f; req1_valid = 1'b1;
      end
      #1;
      chk($sformatf("op%0d accept ready", r), {31'd0, (r == 0) ? req0_ready : req1_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk($sformatf("op%0d exec no rsp", r), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      tick();
      chk($sformatf("op%0d rsp valids", r), {30'd0, rsp1_valid, rsp0_valid}, (r == 0) ? 32'd1 : 32'd2);
      chk($sformatf("op%0d rsp_data", r), rsp_data, exp_d);
      chk($sformatf("op%0d rsp_err", r), {31'd0, rsp_err}, {31'd0, exp_e});
      tick();
      chk($sformatf("op%0d rsp released", r), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_func = '0;
      req1_a = '0; req1_b = '0; req1_func = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #3;
      chk_all_zero("por");
      tick();
      tick();
      rst = 1'b0;
      #1;

      // basic add on requester 0
      run_op(0, 32'd5, 32'd7, 3'b001, 32'd12, 1'b0);

      // contention from a fresh reset: requester 0 first, requester 1 waits
      apply_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_a = 32'd10; req0_b = 32'd3; req0_func = 3'b010; req0_valid = 1'b1;
      req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_func = 3'b100; req1_valid = 1'b1;
      #1;
      chk("cont r0 ready", {31'd0, req0_ready}, 32'd1);
      chk("cont r1 ready", {31'd0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("cont exec r1 ready", {31'd0, req1_ready}, 32'd0);
      tick();
      chk("cont rsp0 valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
      chk("cont rsp0 data", rsp_data, 32'd7);
      chk("cont resp r1 ready", {31'd0, req1_ready}, 32'd0);
      tick();
      chk("cont r1 ready idle", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("cont rsp1 valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      chk("cont rsp1 data", rsp_data, 32'h0000_00FF);
      tick();

      // both held valid: grants alternate 0,1,0,1
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("alt%0d ready pair", i), {30'd0, req1_ready, req0_ready},
             (i % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         tick();
         chk($sformatf("alt%0d rsp valids", i), {30'd0, rsp1_valid, rsp0_valid},
             (i % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("alt%0d rsp data", i), rsp_data, (i % 2 == 0) ? 32'd7 : 32'h0000_00FF);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // signed compare and wrap-around
      run_op(1, 32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1, 1'b0);
      run_op(1, 32'd1, 32'hFFFF_FFFF, 3'b101, 32'd0, 1'b0);
      run_op(1, 32'hFFFF_FFFF, 32'd1, 3'b001, 32'd0, 1'b0);

      // response held under back-pressure while requester 1 waits
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b1;
      req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F; req0_func = 3'b011; req0_valid = 1'b1;
      #1;
      chk("hold accept", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_a = 32'd2; req1_b = 32'd3; req1_func = 3'b001; req1_valid = 1'b1;
      #1;
      chk("hold exec r1 ready", {31'd0, req1_ready}, 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d rsp0 valid", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
         chk($sformatf("hold%0d rsp data", i), rsp_data, 32'h0F0F_0000);
         chk($sformatf("hold%0d r1 ready", i), {31'd0, req1_ready}, 32'd0);
         tick();
      end
      rsp0_ready = 1'b1;
      #1;
      chk("hold take r1 ready", {31'd0, req1_ready}, 32'd0);
      tick();
      chk("hold released", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("hold kept data", rsp_data, 32'h0F0F_0000);
      chk("hold r1 ready after", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("hold rsp1 data", rsp_data, 32'd5);
      chk("hold rsp1 valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      tick();

      // illegal function code then recovery
      run_op(0, 32'd3, 32'd4, 3'b111, 32'd0, 1'b1);
      run_op(0, 32'd1, 32'd1, 3'b001, 32'd2, 1'b0);

      // reset during EXEC aborts the operation
      rsp0_ready = 1'b1;
      req0_a = 32'd1; req0_b = 32'd2; req0_func = 3'b001; req0_valid = 1'b1;
      #1;
      chk("abort accept", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_all_zero("abort");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("abort quiet%0d", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      run_op(1, 32'd9, 32'd1, 3'b010, 32'd8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
